// File: rtl/bcd_scan_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_display_if
//  Description : Four-digit BCD bus from the trigger counters, plus the
//                multiplexed common-anode 7-segment drive returned by the
//                display block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_scan_display_if;
  logic [3:0] BCD0;   // ones digit
  logic [3:0] BCD1;   // tens digit
  logic [3:0] BCD2;   // hundreds digit
  logic [3:0] BCD3;   // thousands digit
  logic [6:0] Seg;    // {g,f,e,d,c,b,a}, active-low
  logic [3:0] An;     // digit enables, active-low

  // Counter side: drives the digits, may observe the display drive
  modport master (
    output BCD0, BCD1, BCD2, BCD3,
    input  Seg, An
  );

  // Display side: consumes the digits, drives the segments and anodes
  modport slave (
    input  BCD0, BCD1, BCD2, BCD3,
    output Seg, An
  );
endinterface : bcd_scan_display_if
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_display
//  Description : Time-multiplexes a four-digit BCD bus onto one common-anode
//                7-segment display. The bus is snapshotted once per full scan
//                so a digit never tears mid-scan. Each digit slot begins with
//                a short all-dark gap to suppress ghosting, and an all-4'hF
//                value (counter overflow) blinks the whole display.
//                Optional macro LEAD_ZERO_BLANK_EN: blank leading zeros of
//                digits 3..1 (digit 0 is always shown).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
  parameter int SCAN_DIV    = 100000,  // cycles per digit slot, >= 2
  parameter int BLANK_CYC   = 1000,    // dark cycles at slot start, < SCAN_DIV
  parameter int BLINK_SCANS = 125      // full scans per blink half-period, >= 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  bcd_scan_display_if.slave    bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYC);
  localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(BLINK_SCANS - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE   = SCAN_W'(1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0][3:0]       snap_q;
  logic [SCAN_W-1:0]     scan_cnt_q;
  logic                  blink_ph_q;
  logic [3:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic                  slot_wrap;
  logic                  scan_end;
  logic                  ovf;
  logic                  digit_off;
  logic [3:0]            cur_digit;
  logic [3:0][3:0]       bcd_in;

  assign bcd_in = {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};

  // --------------------------------------------------------------------------
  // Segment decode, active-low {g,f,e,d,c,b,a}; 4'hF is the overflow dash,
  // the unused codes 10..14 are dark.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_OFF;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'hF:    s = SEG_DASH;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Scan timing: slot counter wraps every SCAN_DIV cycles, the digit index
  // advances on each wrap and a full scan ends on the wrap out of digit 3.
  // --------------------------------------------------------------------------
  assign slot_wrap = (slot_cnt_q == SLOT_LAST);
  assign scan_end  = slot_wrap && (idx_q == 2'd3);

  // Next slot position and digit index
  always_comb begin
    slot_cnt_d = slot_cnt_q + SLOT_ONE;
    idx_d      = idx_q;
    if (slot_wrap) begin
      slot_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  // Slot counter, digit index and once-per-scan snapshot of the digit bus.
  // The snapshot tracks the bus throughout reset so the first scan after
  // release already shows live values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot_cnt_q <= '0;
      idx_q      <= 2'd0;
      snap_q     <= bcd_in;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      if (scan_end) begin
        snap_q <= bcd_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Overflow blink: only an all-4'hF snapshot counts as overflow, so entry
  // and exit line up with snapshot boundaries.
  // --------------------------------------------------------------------------
  assign ovf = (snap_q[0] == 4'hF) && (snap_q[1] == 4'hF) &&
               (snap_q[2] == 4'hF) && (snap_q[3] == 4'hF);

  // Count full scans while in overflow and flip the blink phase each
  // half-period; outside overflow the blink restarts from a lit phase.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_cnt_q <= '0;
      blink_ph_q <= 1'b0;
    end else if (!ovf) begin
      scan_cnt_q <= '0;
      blink_ph_q <= 1'b0;
    end else if (scan_end) begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        blink_ph_q <= ~blink_ph_q;
      end else begin
        scan_cnt_q <= scan_cnt_q + SCAN_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero suppression of the currently selected digit
  // --------------------------------------------------------------------------
`ifdef LEAD_ZERO_BLANK_EN
  logic [3:0] lz_blank;

  // A digit is a leading zero when it and every higher digit are zero;
  // any non-zero code (including 4'hF and 10..14) stops the run.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (snap_q[3] == 4'd0);
    lz_blank[2] = lz_blank[3] && (snap_q[2] == 4'd0);
    lz_blank[1] = lz_blank[2] && (snap_q[1] == 4'd0);
    lz_blank[0] = 1'b0;
  end

  assign digit_off = lz_blank[idx_q];
`else
  assign digit_off = 1'b0;
`endif

  assign cur_digit = snap_q[idx_q];

  // --------------------------------------------------------------------------
  // Display drive
  // --------------------------------------------------------------------------
  // Anode and segment values for the next cycle; segments are forced dark
  // whenever no anode is enabled.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if ((slot_cnt_q >= SLOT_BLANK) && !(ovf && blink_ph_q) && !digit_off) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_decode(cur_digit);
    end
  end

  // Registered anode/segment outputs, dark out of reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.An  = an_q;
  assign bus.Seg = seg_q;

endmodule : bcd_scan_display
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_scan_display
//  Description : Directed self-checking bench for bcd_scan_display with
//                SCAN_DIV=4, BLANK_CYC=1, BLINK_SCANS=2. Every test starts at
//                a scan boundary (slot 0, digit 0) so cycle c of a scan lights
//                digit c/4 except in the first cycle of each slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] BL = 7'b1111111;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_scan_display_if bus ();

  bcd_scan_display #(
    .SCAN_DIV    (4),
    .BLANK_CYC   (1),
    .BLINK_SCANS (2)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bcd(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
    bus.BCD0 = d0;
    bus.BCD1 = d1;
    bus.BCD2 = d2;
    bus.BCD3 = d3;
  endtask

  // Expected anodes for cycle c (0..15) of a scan, given which digits light
  function automatic logic [3:0] exp_an(input int c, input logic [3:0] lit);
    int d;
    d = c / 4;
    if ((c % 4) == 0 || !lit[d]) return 4'b1111;
    return ~(4'b0001 << d);
  endfunction

  // Expected segments; segs packs the shown patterns {d3,d2,d1,d0}
  function automatic logic [6:0] exp_seg(input int c, input logic [3:0] lit,
                                         input logic [27:0] segs);
    int d;
    d = c / 4;
    if ((c % 4) == 0 || !lit[d]) return BL;
    return segs[d*7 +: 7];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    step();
    n_checks++;
    if (bus.An !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset An: got %b expected 1111", bus.An);
    end
    n_checks++;
    if (bus.Seg !== BL) begin
      n_fail++;
      $display("FAIL reset Seg: got %b expected %b", bus.Seg, BL);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic [6:0] es;
    for (int c = 0; c < 16; c++) begin
      step();
      ea = exp_an(c, 4'hF);
      es = exp_seg(c, 4'hF, {S4, S3, S2, S1});
      n_checks++;
      if (bus.An !== ea || bus.Seg !== es) begin
        n_fail++;
        $display("FAIL scan cycle %0d: An=%b Seg=%b expected An=%b Seg=%b",
                 c, bus.An, bus.Seg, ea, es);
      end
    end
  endtask

  // Inputs change during the digit-2 slot; nothing may move until next scan
  task automatic test_snapshot();
    logic [3:0]  ea;
    logic [6:0]  es;
    logic [27:0] segs;
    for (int c = 0; c < 32; c++) begin
      if (c == 8) set_bcd(4'd7, 4'd2, 4'd3, 4'd9);
      segs = (c < 16) ? {S4, S3, S2, S1} : {S9, S3, S2, S7};
      step();
      ea = exp_an(c % 16, 4'hF);
      es = exp_seg(c % 16, 4'hF, segs);
      n_checks++;
      if (bus.An !== ea || bus.Seg !== es) begin
        n_fail++;
        $display("FAIL snapshot cycle %0d: An=%b Seg=%b expected An=%b Seg=%b",
                 c, bus.An, bus.Seg, ea, es);
      end
    end
  endtask

  // Codes 6/8/9, unused codes 10..13 (lit but dark), and 4'hE stopping
  // leading-zero blanking
  task automatic test_decode();
    logic [3:0]  ea, lit;
    logic [6:0]  es;
    logic [27:0] segs;
    for (int s = 0; s < 6; s++) begin
      if (s == 0) set_bcd(4'd6, 4'd8, 4'd9, 4'd0);
      if (s == 2) set_bcd(4'hA, 4'hB, 4'hC, 4'hD);
      if (s == 4) set_bcd(4'd1, 4'd0, 4'd0, 4'hE);
      lit = 4'hF;
      case (s)
        0:       segs = {S9, S3, S2, S7};
        1: begin segs = {S0, S9, S8, S6}; lit = LZB ? 4'b0111 : 4'b1111; end
        2:       segs = {S0, S9, S8, S6};
        3, 4:    segs = {BL, BL, BL, BL};
        default: segs = {BL, S0, S0, S1};
      endcase
      if (s == 2) lit = LZB ? 4'b0111 : 4'b1111;
      for (int c = 0; c < 16; c++) begin
        step();
        ea = exp_an(c, lit);
        es = exp_seg(c, lit, segs);
        n_checks++;
        if (bus.An !== ea || bus.Seg !== es) begin
          n_fail++;
          $display("FAIL decode scan %0d cycle %0d: An=%b Seg=%b expected An=%b Seg=%b",
                   s, c, bus.An, bus.Seg, ea, es);
        end
      end
    end
  endtask

  // Overflow entry, 2-scan blink, exit to 0005 from the dark phase,
  // re-entry from a clean phase, and exit just as the phase flips
  task automatic test_overflow();
    logic [3:0]  ea, lit;
    logic [6:0]  es;
    logic [27:0] segs;
    for (int s = 0; s < 12; s++) begin
      if (s == 0)  set_bcd(4'hF, 4'hF, 4'hF, 4'hF);
      if (s == 3)  set_bcd(4'd5, 4'd0, 4'd0, 4'd0);
      if (s == 5)  set_bcd(4'hF, 4'hF, 4'hF, 4'hF);
      if (s == 11) set_bcd(4'd0, 4'd0, 4'hF, 4'd0);
      segs = {SD, SD, SD, SD};
      lit  = 4'hF;
      case (s)
        0:       segs = {BL, S0, S0, S1};
        3, 8, 9: lit  = 4'h0;
        4, 5: begin
          segs = {S0, S0, S0, S5};
          lit  = LZB ? 4'b0001 : 4'b1111;
        end
        default: lit = 4'hF;
      endcase
      for (int c = 0; c < 16; c++) begin
        step();
        ea = exp_an(c, lit);
        es = exp_seg(c, lit, segs);
        n_checks++;
        if (bus.An !== ea || bus.Seg !== es) begin
          n_fail++;
          $display("FAIL overflow scan %0d cycle %0d: An=%b Seg=%b expected An=%b Seg=%b",
                   s, c, bus.An, bus.Seg, ea, es);
        end
      end
    end
  endtask

  // A single 4'hF digit shows a dash and never blinks
  task automatic test_partial_dash();
    logic [3:0] ea, lit;
    logic [6:0] es;
    lit = LZB ? 4'b0111 : 4'b1111;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        ea = exp_an(c, lit);
        es = exp_seg(c, lit, {S0, SD, S0, S0});
        n_checks++;
        if (bus.An !== ea || bus.Seg !== es) begin
          n_fail++;
          $display("FAIL partial scan %0d cycle %0d: An=%b Seg=%b expected An=%b Seg=%b",
                   s, c, bus.An, bus.Seg, ea, es);
        end
      end
    end
  endtask

  // Reset pulse inside the digit-2 slot, then a 0040 display
  task automatic test_reset_mid_scan();
    logic [3:0] ea, lit;
    logic [6:0] es;
    set_bcd(4'd0, 4'd4, 4'd0, 4'd0);
    for (int c = 0; c < 9; c++) begin
      step();
      ea = exp_an(c, LZB ? 4'b0111 : 4'b1111);
      es = exp_seg(c, LZB ? 4'b0111 : 4'b1111, {S0, SD, S0, S0});
      n_checks++;
      if (bus.An !== ea || bus.Seg !== es) begin
        n_fail++;
        $display("FAIL pre-reset cycle %0d: An=%b Seg=%b expected An=%b Seg=%b",
                 c, bus.An, bus.Seg, ea, es);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.An !== 4'b1111 || bus.Seg !== BL) begin
      n_fail++;
      $display("FAIL mid-scan reset: An=%b Seg=%b expected An=1111 Seg=%b",
               bus.An, bus.Seg, BL);
    end
    lit = LZB ? 4'b0011 : 4'b1111;
    for (int c = 0; c < 32; c++) begin
      step();
      ea = exp_an(c % 16, lit);
      es = exp_seg(c % 16, lit, {S0, S0, S4, S0});
      n_checks++;
      if (bus.An !== ea || bus.Seg !== es) begin
        n_fail++;
        $display("FAIL post-reset cycle %0d: An=%b Seg=%b expected An=%b Seg=%b",
                 c, bus.An, bus.Seg, ea, es);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
    test_reset();
    test_scan();
    test_snapshot();
    test_decode();
    test_overflow();
    test_partial_dash();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_scan_display
`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Consumer end of the four-digit BCD bus (BCD3..BCD0, digit code 4'b1111 = overflow) driven by the team's trigger-counter blocks.
- Time-multiplexes the four digits onto one common-anode 7-segment display.
- Snapshots the bus once per full scan so digits cannot tear mid-scan.
- Includes ghost-suppression blanking and an overflow blink.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be >= 2.
- BLANK_CYC, 1000: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_SCANS, 125: full 4-digit scans per overflow blink half-period; must be >= 1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- BCD0  in  4  ones digit.
- BCD1  in  4  tens digit.
- BCD2  in  4  hundreds digit.
- BCD3  in  4  thousands digit.
- Seg  out  7  {g,f,e,d,c,b,a}, active-low.
- An  out  4  digit enables, active-low; An[i] selects BCDi.

Behaviour:
- Interface: one clock, Clk; Reset is synchronous and active-high.
- Reset values:
  - slot_cnt=0, idx=0, scan_cnt=0, blink_ph=0.
  - An=4'b1111, Seg=7'b1111111.
  - While Reset is high, the snapshot registers load BCD3..0 every cycle.
- Slot counter: slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
- Digit index: on the wrap cycle, idx advances 0->1->2->3->0.
- Snapshot: loaded from inputs only on the wrap cycle with idx==3, so it is new from the digit-0 slot onward. Input changes at any other time have no effect until the next full scan.
- Output registration:
  - Seg and An are registered.
  - Values in cycle t+1 are a function of (slot_cnt, idx, snapshot, blink_ph) in cycle t. Latency is 1 cycle.
- An rule:
  - 4'b1111 if slot_cnt < BLANK_CYC, or if (ovf && blink_ph).
  - Otherwise ~(4'b0001 << idx).
- Seg rule:
  - Decode of snapshot digit idx; 7'b1111111 whenever An==4'b1111.
  - Decode values:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
    - 15 = dash 0111111.
    - 10..14 = blank 1111111.
- Overflow:
  - ovf = all four snapshot digits == 4'hF.
  - If a partial 4'hF occurs, only those digits show a dash; no blink.
- Blink:
  - While ovf, scan_cnt increments on each idx 3->0 wrap.
  - At BLINK_SCANS-1 it clears and blink_ph toggles.
  - While !ovf, scan_cnt=0 and blink_ph=0, forced the same cycle ovf is evaluated false.
- Ovf entry and exit take effect only at snapshot boundaries.
- Reset mid-scan: the next cycle returns to the reset values; the scan restarts at digit 0.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: leading zeros are blanked.
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if it and digit 3 are 0.
  - Digit 1 is blanked if it and digits 3 and 2 are 0.
  - Digit 0 is never blanked; 0000 displays as "   0".
  - Blanking applies only to value 0. 4'hF or 10..14 in a higher digit stops blanking.
- Undefined: all zeros are displayed. No extra registers or logic are generated.

Test Plan (SCAN_DIV=4, BLANK_CYC=1, BLINK_SCANS=2):
- Reset with BCD=1,2,3,4 (BCD0..3), release, run 16 cycles:
  - In each 4-cycle slot, An=1111 for 1 cycle, then 1110, 1101, 1011, 0111 for 3 cycles each.
  - Seg shows 1111001, 0100100, 0110000, 0011001 in that order.
- Change BCD0 from 1 to 7 during the idx=2 slot:
  - Digit 0 still shows 1111001 for the rest of the scan.
  - Digit 0 shows 1111000 from the next digit-0 slot.
- All inputs 4'hF:
  - After the snapshot, every lit digit shows 0111111.
  - For 2 scans (32 cycles) the display is lit; for the next 2 scans An=1111; the pattern repeats.
  - Then set inputs to 0005: the display lights at the next snapshot with blink_ph=0.
- Only BCD2=4'hF, others 0:
  - Digit 2 shows a dash, the others show 1000000; no blinking across 8 scans.
- Assert Reset for 1 cycle mid-slot at idx=2:
  - Next cycle: An=1111, Seg=1111111.
  - The first lit digit afterwards is digit 0, at cycle 2 after release.
- With LEAD_ZERO_BLANK_EN, BCD3..0=0,0,4,0:
  - Digits 3 and 2 are dark (An never 0111/1011 lit).
  - Digit 1 shows 0011001; digit 0 shows 1000000.
  - Without the macro, digits 3 and 2 show 1000000.
